// File: rtl/serial_add_pkg.sv
// ============================================================================
// Module  : serial_add_pkg
// Purpose : Shared FSM state encoding and slice width for the serial adder.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package serial_add_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/serial_add_ctrl_nibble_adder.sv
// ============================================================================
// Module  : nibble_adder
// Purpose : 4-bit ripple-carry adder built from four full-adder bit cells.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module nibble_adder
  import serial_add_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] s,
  output logic                cout
);

  logic [NIBBLE_W:0] w_c;

  assign w_c[0] = cin;

  generate
    for (genvar gi = 0; gi < NIBBLE_W; gi++) begin : g_bit
      assign s[gi]     = a[gi] ^ b[gi] ^ w_c[gi];
      assign w_c[gi+1] = (a[gi] & b[gi]) | (w_c[gi] & (a[gi] ^ b[gi]));
    end
  endgenerate

  assign cout = w_c[NIBBLE_W];

endmodule

`default_nettype wire

// File: rtl/serial_add_ctrl.sv
// ============================================================================
// Module  : serial_add_ctrl
// Purpose : Nibble-serial add/subtract; one 4-bit slice per RUN cycle.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(NIBBLES - 1);

  state_t              r_state;
  state_t              w_next;
  logic [WIDTH-1:0]    r_a;
  logic [WIDTH-1:0]    r_b;
  logic [WIDTH-1:0]    r_work;
  logic [WIDTH-1:0]    r_sum;
  logic                r_carry;
  logic                r_cout;
  logic                r_ovf;
  logic [IDX_W-1:0]    r_idx;

  int                  w_base;
  logic [NIBBLE_W-1:0] w_a_nib;
  logic [NIBBLE_W-1:0] w_b_nib;
  logic [NIBBLE_W-1:0] w_s;
  logic                w_cout;
  logic [WIDTH-1:0]    w_result;
  logic                w_accept;
  logic                w_last;

  always_comb begin
    w_base  = int'(r_idx) * NIBBLE_W;
    w_a_nib = r_a[w_base +: NIBBLE_W];
    w_b_nib = r_b[w_base +: NIBBLE_W];
  end

  nibble_adder u_slice (
    .a    (w_a_nib),
    .b    (w_b_nib),
    .cin  (r_carry),
    .s    (w_s),
    .cout (w_cout)
  );

  // The final slice result bypasses r_work so sum loads on the same edge.
  assign w_result = {w_s, r_work[WIDTH-NIBBLE_W-1:0]};
  assign w_accept = (r_state == IDLE) && start;
  assign w_last   = (r_state == RUN) && (r_idx == C_LAST_IDX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = RUN;
      RUN:     if (r_idx == C_LAST_IDX) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    ready = (r_state == IDLE);
    busy  = (r_state == RUN);
    done  = (r_state == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a     <= '0;
      r_b     <= '0;
      r_work  <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_idx   <= '0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= sub ? ~b : b;
      r_carry <= sub;
      r_idx   <= '0;
    end else if (r_state == RUN) begin
      r_work[w_base +: NIBBLE_W] <= w_s;
      r_carry <= w_cout;
      r_idx   <= r_idx + 1'b1;
      if (w_last) begin
        r_sum  <= w_result;
        r_cout <= w_cout;
        r_ovf  <= (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_result[WIDTH-1] != r_a[WIDTH-1]);
      end
    end
  end

  assign sum   = r_sum;
  assign c_out = r_cout;
  assign ovf   = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
// ============================================================================
// Module  : tb_serial_add_ctrl
// Purpose : Scoreboard bench for serial_add_ctrl (WIDTH=16).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_serial_add_ctrl;

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    int          done_cyc;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        start;
  logic        sub;
  logic [15:0] a;
  logic [15:0] b;
  logic        ready;
  logic        busy;
  logic        done;
  logic [15:0] sum;
  logic        c_out;
  logic        ovf;

  exp_t        q[$];
  int          n_pass;
  int          n_total;
  int          cyc;

  serial_add_ctrl #(.WIDTH(16)) dut (
    .clk   (clk),
    .reset (rst),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .c_out (c_out),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic exp_t model(input logic s, input logic [15:0] av, input logic [15:0] bv);
    exp_t        e;
    logic [15:0] bb;
    logic [16:0] full;
    bb       = s ? ~bv : bv;
    full     = {1'b0, av} + {1'b0, bb} + {16'd0, s};
    e.sum    = full[15:0];
    e.cout   = full[16];
    e.ovf    = (av[15] == bb[15]) && (full[15] != av[15]);
    e.done_cyc = 0;
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("sum",     {16'd0, sum},  {16'd0, e.sum});
        chk("c_out",   {31'd0, c_out}, {31'd0, e.cout});
        chk("ovf",     {31'd0, ovf},  {31'd0, e.ovf});
        chk("latency", cyc,           e.done_cyc);
      end
    end
  end

  task automatic issue(input logic s, input logic [15:0] av, input logic [15:0] bv,
                       input logic [15:0] es, input logic ec, input logic eo);
    int   k;
    exp_t e;
    k = 0;
    @(negedge clk);
    while (!ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!ready) chk("ready_timeout", 32'd0, 32'd1);
    start = 1'b1;
    sub   = s;
    a     = av;
    b     = bv;
    e.sum = es; e.cout = ec; e.ovf = eo; e.done_cyc = cyc + 1 + 4;
    q.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = 16'($urandom);
    b     = 16'($urandom);
    sub   = 1'($urandom);
  endtask

  initial begin
    int   last_acc;
    int   k;
    exp_t e;
    n_pass = 0; n_total = 0; cyc = 0;
    rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_busy",  {31'd0, busy},  32'd0);
    chk("rst_sum",   {16'd0, sum},   32'd0);
    rst = 1'b0;

    issue(1'b0, 16'h1234, 16'h0FCC, 16'h2200, 1'b0, 1'b0);
    issue(1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0);
    issue(1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1);
    issue(1'b0, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1);
    issue(1'b1, 16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b0);
    issue(1'b1, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0);
    issue(1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1);

    // Abort an operation after its second slice; no done may follow.
    k = 0;
    @(negedge clk);
    while (!ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    start = 1'b1; sub = 1'b0; a = 16'h1234; b = 16'h1111;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_sum",   {16'd0, sum},   32'd0);
    chk("abort_cout",  {31'd0, c_out}, 32'd0);
    chk("abort_ovf",   {31'd0, ovf},   32'd0);
    chk("abort_ready", {31'd0, ready}, 32'd1);
    chk("abort_busy",  {31'd0, busy},  32'd0);
    chk("abort_done",  {31'd0, done},  32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    issue(1'b0, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0);

    // Start held high while operands change every cycle.
    k = 0;
    @(negedge clk);
    while (!ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    last_acc = -1;
    start = 1'b1;
    for (int i = 0; i < 20; i++) begin
      a   = 16'h0F0F + 16'(i) * 16'h0123;
      b   = 16'hFFFF - 16'(i) * 16'h0321;
      sub = 1'(i);
      if (ready) begin
        e = model(sub, a, b);
        e.done_cyc = cyc + 1 + 4;
        q.push_back(e);
        if (last_acc >= 0) chk("accept_period", cyc + 1 - last_acc, 32'd6);
        last_acc = cyc + 1;
      end
      @(negedge clk);
    end
    start = 1'b0;

    k = 0;
    while (q.size() != 0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (q.size() != 0) chk("drain_timeout", q.size(), 32'd0);
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, operand/result width in bits, a multiple of 4 and at least 8.
REQ-002 The block SHALL derive NIBBLES = WIDTH/4, the number of 4-bit slice passes per operation.
REQ-003 Port clk  input  1  the single clock; all state is updated on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port start  input  1  request to begin one operation.
REQ-006 Port sub  input  1  operation select: 0 = a+b, 1 = a-b.
REQ-007 Port a  input  WIDTH  first operand.
REQ-008 Port b  input  WIDTH  second operand.
REQ-009 Port ready  output  1  high when a start can be accepted.
REQ-010 Port busy  output  1  high while slices are being computed.
REQ-011 Port done  output  1  one-cycle completion pulse.
REQ-012 Port sum  output  WIDTH  result of the last completed operation.
REQ-013 Port c_out  output  1  carry out of the MSB (for sub: 1 = no borrow).
REQ-014 Port ovf  output  1  two's-complement signed overflow of the last completed operation.

Function
REQ-015 The FSM SHALL have states IDLE, RUN and DONE; ready = (IDLE), busy = (RUN), done = (DONE).
REQ-016 In IDLE with start=1 at a rising edge, the block SHALL latch a, sub and (sub ? ~b : b), set carry register = sub, clear slice index to 0, and enter RUN.
REQ-017 Each RUN edge SHALL add latched operand nibble[idx] with carry register through one 4-bit adder slice, store the 4-bit result into working nibble[idx], update the carry register, and increment idx.
REQ-018 The RUN edge with idx = NIBBLES-1 SHALL load sum, c_out and ovf from the completed working result and enter DONE.
REQ-019 ovf SHALL equal (a[MSB] == b'[MSB]) && (result[MSB] != a[MSB]), with b' the possibly inverted latched operand.
REQ-020 DONE SHALL last exactly one cycle, then return to IDLE unconditionally.
REQ-021 Latency: done SHALL be high in the cycle following the NIBBLES-th edge after the accepting edge; minimum start-to-start period is NIBBLES+2 cycles.
REQ-022 start, a, b and sub SHALL be ignored in RUN and DONE; input changes after acceptance SHALL NOT affect the result.
REQ-023 sum, c_out and ovf SHALL hold their value from one DONE to the next and SHALL NOT change during RUN.
REQ-024 Arithmetic SHALL be modulo 2^WIDTH; carry out of the last slice is c_out only, never fed back.

Reset
REQ-025 Asserting reset SHALL immediately force IDLE, idx=0, carry=0, sum=0, c_out=0, ovf=0, done=0, busy=0, ready=1 regardless of clock.
REQ-026 Reset during RUN SHALL abort the operation with no done pulse; the first start after deassertion SHALL complete normally.

Structure
REQ-027 A shared package serial_add_pkg SHALL hold the state enum (IDLE, RUN, DONE) and constant NIBBLE_W = 4.
REQ-028 The 4-bit slice SHALL be a sub-module nibble_adder (a[4], b[4], cin -> s[4], cout), ripple of four full-adder bit cells, instantiated once.

Verification
REQ-029 a=0x1234, b=0x0FCC, sub=0, start pulse -> done exactly 4 edges after accept, sum=0x2200, c_out=0, ovf=0.
REQ-030 a=0xFFFF, b=0x0001, sub=0 -> sum=0x0000, c_out=1, ovf=0; a=0x7FFF, b=0x0001 -> sum=0x8000, c_out=0, ovf=1.
REQ-031 sub=1: a=0x0005, b=0x0007 -> sum=0xFFFE, c_out=0, ovf=0; a=0x8000, b=0x0001 -> sum=0x7FFF, c_out=1, ovf=1.
REQ-032 reset asserted mid-RUN (second slice) -> all outputs zero asynchronously, ready=1, no done; subsequent 0x0001+0x0001 -> sum=0x0002.
REQ-033 start held high with operands changed every cycle -> only IDLE-sampled operands used; done pulses every 6 cycles; results match those sampled operands.
